semaforo_cruce: RTL and testbench



---
 rtl/semaforo_cruce.sv | 271 +++++++++++++++++++++++++++
 tb/tb_semaforo_cruce.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/semaforo_cruce.sv
// Two-way intersection controller with all-red clearance and a synchronised pedestrian request.
// Define SEMAFORO_NIGHT_EN to add the night flashing mode driven by the night input.
module semaforo_cruce #(
    parameter int CNT_W      = 32,
    parameter int GREEN_A    = 20000000,
    parameter int GREEN_B    = 10000000,
    parameter int YELLOW     = 10000000,
    parameter int ALLRED     = 5000000,
    parameter int MIN_GREEN  = 5000000,
    parameter int FLASH_HALF = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    input  logic night,
    output logic a_red,
    output logic a_yellow,
    output logic a_green,
    output logic b_red,
    output logic b_yellow,
    output logic b_green,
    output logic walk,
    output logic req_pending
);

`ifdef SEMAFORO_NIGHT_EN
    typedef enum logic [2:0] {
        ALLRED_B = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        ALLRED_A = 3'd3,
        B_GREEN  = 3'd4,
        B_YELLOW = 3'd5,
        NIGHT    = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ALLRED_B = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        ALLRED_A = 3'd3,
        B_GREEN  = 3'd4,
        B_YELLOW = 3'd5
    } state_t;
`endif

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] GA_END = CNT_W'(GREEN_A - 1);
    localparam logic [CNT_W-1:0] GB_END = CNT_W'(GREEN_B - 1);
    localparam logic [CNT_W-1:0] YE_END = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_END = CNT_W'(ALLRED - 1);
    localparam logic [CNT_W-1:0] MG_END = CNT_W'(MIN_GREEN - 1);

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [CNT_W-1:0]   end_s;
    logic               last_s;
    logic               req_r;
    logic               req_nx_s;
    logic               sync1_r;
    logic               sync2_r;
    logic               prev_r;
    logic               edge_s;
    logic [6:0]         lamps_s;

`ifdef SEMAFORO_NIGHT_EN
    localparam logic [CNT_W-1:0] FL_END = CNT_W'(FLASH_HALF - 1);
    logic               flash_r;
    logic               flash_nx_s;
`else
    logic               unused_night_s;
    assign unused_night_s = night | (FLASH_HALF == 0);
`endif

    // Button synchroniser and rising-edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~prev_r;
    assign last_s = (cnt_r == end_s);

    // Last count value of the current phase
    always_comb begin
        end_s = AR_END;
        case (state_r)
            ALLRED_B: end_s = AR_END;
            A_GREEN:  end_s = GA_END;
            A_YELLOW: end_s = YE_END;
            ALLRED_A: end_s = AR_END;
            B_GREEN:  end_s = GB_END;
            B_YELLOW: end_s = YE_END;
`ifdef SEMAFORO_NIGHT_EN
            NIGHT:    end_s = FL_END;
`endif
            default:  end_s = AR_END;
        endcase
    end

    // Next phase, counter and request
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r + ONE;
`ifdef SEMAFORO_NIGHT_EN
        flash_nx_s = flash_r;
`endif
        case (state_r)
            ALLRED_B: begin
                if (last_s) begin
                    cnt_nx_s = '0;
`ifdef SEMAFORO_NIGHT_EN
                    if (night) begin
                        state_nx_s = NIGHT;
                        flash_nx_s = 1'b1;
                    end else begin
                        state_nx_s = A_GREEN;
                    end
`else
                    state_nx_s = A_GREEN;
`endif
                end else begin
                    state_nx_s = ALLRED_B;
                end
            end
            A_GREEN: begin
                // A waiting pedestrian may shorten green once the minimum has elapsed
                if (last_s || (req_r && (cnt_r >= MG_END))) begin
                    state_nx_s = A_YELLOW;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = A_GREEN;
                end
            end
            A_YELLOW: begin
                if (last_s) begin
                    state_nx_s = ALLRED_A;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = A_YELLOW;
                end
            end
            ALLRED_A: begin
                if (last_s) begin
                    cnt_nx_s = '0;
`ifdef SEMAFORO_NIGHT_EN
                    if (night) begin
                        state_nx_s = NIGHT;
                        flash_nx_s = 1'b1;
                    end else begin
                        state_nx_s = B_GREEN;
                    end
`else
                    state_nx_s = B_GREEN;
`endif
                end else begin
                    state_nx_s = ALLRED_A;
                end
            end
            B_GREEN: begin
                if (last_s) begin
                    state_nx_s = B_YELLOW;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = B_GREEN;
                end
            end
            B_YELLOW: begin
                if (last_s) begin
                    state_nx_s = ALLRED_B;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = B_YELLOW;
                end
            end
`ifdef SEMAFORO_NIGHT_EN
            NIGHT: begin
                // Leave night mode only on a half-period boundary
                if (last_s) begin
                    cnt_nx_s = '0;
                    if (night) begin
                        state_nx_s = NIGHT;
                        flash_nx_s = ~flash_r;
                    end else begin
                        state_nx_s = ALLRED_B;
                    end
                end else begin
                    state_nx_s = NIGHT;
                end
            end
`endif
            default: begin
                state_nx_s = ALLRED_B;
                cnt_nx_s   = '0;
            end
        endcase

        // Walk is already granted in B_GREEN, so the request clears on entry and later edges drop
        if ((state_r == B_GREEN) || (state_nx_s == B_GREEN)) begin
            req_nx_s = 1'b0;
`ifdef SEMAFORO_NIGHT_EN
        end else if ((state_r == NIGHT) || (state_nx_s == NIGHT)) begin
            req_nx_s = 1'b0;
`endif
        end else begin
            req_nx_s = req_r | edge_s;
        end
    end

    // Lamp pattern {a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk} for the next phase
    always_comb begin
        lamps_s = 7'b100_100_0;
        case (state_nx_s)
            ALLRED_B: lamps_s = 7'b100_100_0;
            A_GREEN:  lamps_s = 7'b001_100_0;
            A_YELLOW: lamps_s = 7'b010_100_0;
            ALLRED_A: lamps_s = 7'b100_100_0;
            B_GREEN:  lamps_s = 7'b100_001_1;
            B_YELLOW: lamps_s = 7'b100_010_0;
`ifdef SEMAFORO_NIGHT_EN
            NIGHT:    lamps_s = {1'b0, flash_nx_s, 1'b0, 1'b0, flash_nx_s, 1'b0, 1'b0};
`endif
            default:  lamps_s = 7'b100_100_0;
        endcase
    end

    // Phase state, counter, request and registered lamp outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ALLRED_B;
            cnt_r       <= '0;
            req_r       <= 1'b0;
`ifdef SEMAFORO_NIGHT_EN
            flash_r     <= 1'b0;
`endif
            a_red       <= 1'b1;
            a_yellow    <= 1'b0;
            a_green     <= 1'b0;
            b_red       <= 1'b1;
            b_yellow    <= 1'b0;
            b_green     <= 1'b0;
            walk        <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            req_r       <= req_nx_s;
`ifdef SEMAFORO_NIGHT_EN
            flash_r     <= flash_nx_s;
`endif
            a_red       <= lamps_s[6];
            a_yellow    <= lamps_s[5];
            a_green     <= lamps_s[4];
            b_red       <= lamps_s[3];
            b_yellow    <= lamps_s[2];
            b_green     <= lamps_s[1];
            walk        <= lamps_s[0];
            req_pending <= req_nx_s;
        end
    end

endmodule

// File: tb/tb_semaforo_cruce.sv
// Bench for semaforo_cruce: per-cycle vector table with a scoreboard queue, plus a mid-run reset
// sequence; night-mode vectors are added when SEMAFORO_NIGHT_EN is defined.
module tb_semaforo_cruce;

    logic clk = 1'b0;
    logic rst_n;
    logic button;
    logic night;
    logic a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, req_pending;

    always #5 clk = ~clk;

    semaforo_cruce #(
        .CNT_W(8), .GREEN_A(8), .GREEN_B(5), .YELLOW(3),
        .ALLRED(2), .MIN_GREEN(4), .FLASH_HALF(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .night(night),
        .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
        .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
        .walk(walk), .req_pending(req_pending)
    );

    // {a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, req_pending}
    wire [7:0] outs_s = {a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, req_pending};

    localparam logic [7:0] AR = 8'b1001_0000;
    localparam logic [7:0] AG = 8'b0011_0000;
    localparam logic [7:0] AY = 8'b0101_0000;
    localparam logic [7:0] BG = 8'b1000_0110;
    localparam logic [7:0] BY = 8'b1000_1000;
    localparam logic [7:0] NY = 8'b0100_1000;
    localparam logic [7:0] RQ = 8'b0000_0001;

    typedef struct {
        int         len;
        logic       btn;
        logic       nt;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         s5_end;

    task automatic add(input int len, input logic btn, input logic nt, input logic [7:0] e);
        vec_t v;
        v.len = len;
        v.btn = btn;
        v.nt  = nt;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] want;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", tag, outs_s);
        end else begin
            want = exp_q.pop_front();
            if (outs_s !== want) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", tag, outs_s, want);
            end
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            for (int c = 0; c < vecs[i].len; c++) begin
                @(negedge clk);
                button = vecs[i].btn;
                night  = vecs[i].nt;
                exp_q.push_back(vecs[i].exp);
                @(posedge clk);
                #1;
                check_pop($sformatf("vec%0d.%0d", i, c));
            end
        end
    endtask

    initial begin
        // Plain cycle from reset release: a_green at 2, a_yellow 10, b_green 15, b_yellow 20, a_green 25
        add(1, 1'b0, 1'b0, AR); add(8, 1'b0, 1'b0, AG); add(3, 1'b0, 1'b0, AY);
        add(2, 1'b0, 1'b0, AR); add(5, 1'b0, 1'b0, BG); add(3, 1'b0, 1'b0, BY);
        add(2, 1'b0, 1'b0, AR); add(1, 1'b0, 1'b0, AG);
        // Button held 12 cycles from A_GREEN cnt=0: request after 3 edges, green cut at MIN_GREEN, one request only
        add(2, 1'b1, 1'b0, AG); add(1, 1'b1, 1'b0, AG | RQ); add(3, 1'b1, 1'b0, AY | RQ);
        add(2, 1'b1, 1'b0, AR | RQ); add(4, 1'b1, 1'b0, BG); add(1, 1'b0, 1'b0, BG);
        add(3, 1'b0, 1'b0, BY); add(2, 1'b0, 1'b0, AR); add(1, 1'b0, 1'b0, AG);
        // Button rises at A_GREEN cnt=6: full green, request latched in A_YELLOW
        add(6, 1'b0, 1'b0, AG); add(1, 1'b1, 1'b0, AG); add(1, 1'b1, 1'b0, AY);
        add(1, 1'b1, 1'b0, AY | RQ); add(1, 1'b0, 1'b0, AY | RQ); add(2, 1'b0, 1'b0, AR | RQ);
        add(5, 1'b0, 1'b0, BG); add(3, 1'b0, 1'b0, BY); add(2, 1'b0, 1'b0, AR); add(1, 1'b0, 1'b0, AG);
        // Button toggled in B_GREEN is dropped; next A_GREEN runs the full 8 cycles
        add(7, 1'b0, 1'b0, AG); add(3, 1'b0, 1'b0, AY); add(2, 1'b0, 1'b0, AR);
        add(1, 1'b1, 1'b0, BG); add(1, 1'b0, 1'b0, BG); add(1, 1'b1, 1'b0, BG); add(2, 1'b0, 1'b0, BG);
        add(3, 1'b0, 1'b0, BY); add(2, 1'b0, 1'b0, AR); add(8, 1'b0, 1'b0, AG); add(1, 1'b0, 1'b0, AY);
        // Request latched in A_YELLOW, pending in ALLRED_A before the mid-run reset
        add(1, 1'b1, 1'b0, AY); add(1, 1'b0, 1'b0, AY); add(1, 1'b0, 1'b0, AR | RQ);
        s5_end = vecs.size() - 1;
`ifdef SEMAFORO_NIGHT_EN
        // Night requested in A_GREEN: entry after ALLRED_A, flash 1,1,0,0, exit via ALLRED_B
        add(3, 1'b0, 1'b1, AY); add(2, 1'b0, 1'b1, AR); add(2, 1'b0, 1'b1, NY);
        add(2, 1'b0, 1'b1, 8'h00); add(2, 1'b0, 1'b1, NY); add(2, 1'b0, 1'b0, AR);
        add(1, 1'b0, 1'b0, AG);
`endif

        rst_n  = 1'b0;
        button = 1'b0;
        night  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(AR);
        check_pop("reset");
        #1 rst_n = 1'b1;

        run_range(0, s5_end);

        // Asynchronous reset with a pending request: outputs return before any clock edge
        #3 rst_n = 1'b0;
        exp_q.push_back(AR);
        #1;
        check_pop("async_reset");
        @(posedge clk);
        #1;
        exp_q.push_back(AR);
        check_pop("reset_hold");
        #1 rst_n = 1'b1;
        run_range(0, 1);
`ifdef SEMAFORO_NIGHT_EN
        run_range(s5_end + 1, vecs.size() - 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
